// File: rtl/fc_argmax_classifier.sv
// ---------------------------------------------------------------------------
// fc_argmax_classifier
//
// Final classification stage behind the last fully-connected layer. The
// logits of one image arrive as a valid/ready stream in class order
// 0..NUM_CLASSES-1. The block keeps a running maximum and the index where
// that maximum first appeared. On the last logit it publishes the winning
// class on `result` and raises `final_out_valid` for one cycle.
//
// Parameters
//   NUM_CLASSES  logits per image
//   DATA_W       signed logit width
//   IDX_W        class index width (>= clog2(NUM_CLASSES))
//
// Ports
//   clock            system clock, rising edge
//   reset            asynchronous active-high reset, clears all state
//   start            one-cycle pulse that arms collection of a new image
//   logit_valid_in   logit_data_in carries a logit this cycle
//   logit_data_in    signed logit, class order 0..NUM_CLASSES-1
//   logit_ready_out  block accepts a logit this cycle (state ACCUM)
//   busy             collecting logits (state ACCUM)
//   result           winning class index, held until the next decision
//   final_out_valid  one-cycle pulse: result was updated this cycle
// ---------------------------------------------------------------------------
module fc_argmax_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 16,
  parameter int IDX_W       = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     logit_valid_in,
  input  logic signed [DATA_W-1:0] logit_data_in,
  output logic                     logit_ready_out,
  output logic                     busy,
  output logic [IDX_W-1:0]         result,
  output logic                     final_out_valid
);

  localparam int CNT_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                     state_q,  state_d;
  logic [CNT_W-1:0]           count_q,  count_d;
  logic signed [DATA_W-1:0]   max_q,    max_d;
  logic [IDX_W-1:0]           idx_q,    idx_d;
  logic [IDX_W-1:0]           result_q, result_d;
  logic                       fov_q,    fov_d;
  logic                       ready_q,  ready_d;
  logic                       busy_q,   busy_d;

  logic                       accept_s;
  logic                       take_s;
  logic                       last_beat_s;
  logic [IDX_W-1:0]           beat_idx_s;

  // Beat qualification: handshake, new-maximum decision and last-beat detect.
  always_comb begin
    accept_s    = logit_valid_in & ready_q;
    beat_idx_s  = IDX_W'(count_q);
    last_beat_s = (count_q == LAST_BEAT);
    // Strict greater-than keeps the lower index on ties; beat 0 always seeds.
    if ((count_q == '0) || (logit_data_in > max_q)) begin
      take_s = 1'b1;
    end else begin
      take_s = 1'b0;
    end
  end

  // Next-state and datapath update for the collect/decide FSM.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    max_d    = max_q;
    idx_d    = idx_q;
    result_d = result_q;
    fov_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          count_d = '0;
          max_d   = '0;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end

      ACCUM: begin
        if (start) begin
          // Restart wins over a concurrent beat; the previous result stays.
          state_d = ACCUM;
          count_d = '0;
          max_d   = '0;
          idx_d   = '0;
        end else if (accept_s) begin
          if (take_s) begin
            max_d = logit_data_in;
            idx_d = beat_idx_s;
          end else begin
            max_d = max_q;
            idx_d = idx_q;
          end
          if (last_beat_s) begin
            // Publish on the same edge, including this beat's compare.
            state_d  = DONE;
            count_d  = '0;
            result_d = take_s ? beat_idx_s : idx_q;
            fov_d    = 1'b1;
          end else begin
            state_d = ACCUM;
            count_d = count_q + CNT_W'(1);
          end
        end else begin
          state_d = ACCUM;
        end
      end

      DONE: begin
        if (start) begin
          state_d = ACCUM;
          count_d = '0;
          max_d   = '0;
          idx_d   = '0;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
        max_d   = '0;
        idx_d   = '0;
      end
    endcase

    // Handshake/status outputs are registered copies of the next state.
    if (state_d == ACCUM) begin
      ready_d = 1'b1;
      busy_d  = 1'b1;
    end else begin
      ready_d = 1'b0;
      busy_d  = 1'b0;
    end
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      max_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      fov_q    <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      max_q    <= max_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      fov_q    <= fov_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign logit_ready_out = ready_q;
  assign busy            = busy_q;
  assign result          = result_q;
  assign final_out_valid = fov_q;

endmodule

// File: tb/tb_fc_argmax_classifier.sv
// ---------------------------------------------------------------------------
// Testbench for fc_argmax_classifier. Stimulus pushes the expected class and
// the cycle in which the decision pulse must appear into a queue; a monitor
// on the falling edge pops and compares on every final_out_valid pulse.
// ---------------------------------------------------------------------------
module tb_fc_argmax_classifier;

  logic              clock;
  logic              reset;
  logic              start;
  logic              logit_valid_in;
  logic signed [15:0] logit_data_in;
  logic              logit_ready_out;
  logic              busy;
  logic [3:0]        result;
  logic              final_out_valid;

  typedef struct {
    int idx;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   img[10];

  fc_argmax_classifier #(
    .NUM_CLASSES(10),
    .DATA_W     (16),
    .IDX_W      (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .logit_valid_in (logit_valid_in),
    .logit_data_in  (logit_data_in),
    .logit_ready_out(logit_ready_out),
    .busy           (busy),
    .result         (result),
    .final_out_valid(final_out_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks = checks + 1;
    if (act != req) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every decision pulse must match the head of the scoreboard.
  always @(negedge clock) begin
    if (final_out_valid) begin
      if (exp_q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL unexpected_pulse: got result %0d at cycle %0d, expected no pulse",
                 result, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_result", int'(result), e.idx);
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send(input int d);
    logit_valid_in = 1'b1;
    logit_data_in  = 16'(d);
    @(posedge clock); #1;
    logit_valid_in = 1'b0;
  endtask

  // Send img[0..9]; with gaps, an idle cycle precedes every beat after the first.
  task automatic run_image(input bit gaps, input int exp_idx, input string tag);
    for (int i = 0; i < 10; i++) begin
      if (gaps && i > 0) begin
        @(posedge clock); #1;
      end
      send(img[i]);
    end
    // Last beat taken on the edge just passed; pulse is visible this cycle.
    exp_q.push_back('{idx: exp_idx, cyc: cyc});
    chk({tag, "_ready_after"}, int'(logit_ready_out), 0);
    chk({tag, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; logit_valid_in = 1'b0; logit_data_in = 16'sd0;

    // T1: reset state, then logits in IDLE are ignored.
    repeat (3) @(posedge clock);
    #1;
    chk("t1_result", int'(result), 0);
    chk("t1_fov", int'(final_out_valid), 0);
    chk("t1_ready", int'(logit_ready_out), 0);
    chk("t1_busy", int'(busy), 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) send(100 + i);
    chk("t1_idle_ready", int'(logit_ready_out), 0);
    chk("t1_idle_busy", int'(busy), 0);

    // T2: tie on 7 at indices 2 and 7 -> lower index wins.
    start_pulse();
    chk("t2_ready_armed", int'(logit_ready_out), 1);
    chk("t2_busy_armed", int'(busy), 1);
    img = '{-5, 3, 7, 2, -1, 0, 6, 7, 1, -8};
    run_image(1'b0, 2, "t2");
    @(posedge clock); #1;
    chk("t2_result_held", int'(result), 2);

    // T3: all minimum, then all maximum -> index 0 both times.
    start_pulse();
    img = '{-32768, -32768, -32768, -32768, -32768,
            -32768, -32768, -32768, -32768, -32768};
    run_image(1'b0, 0, "t3a");
    start_pulse();
    img = '{32767, 32767, 32767, 32767, 32767,
            32767, 32767, 32767, 32767, 32767};
    run_image(1'b0, 0, "t3b");

    // T4: gapped stream, max on the last beat; extra beats in DONE ignored.
    start_pulse();
    img = '{100, -200, 300, -400, 500, 600, -700, 800, 900, 32767};
    run_image(1'b1, 9, "t4");
    for (int i = 0; i < 3; i++) send(32767);
    chk("t4_done_ready", int'(logit_ready_out), 0);
    chk("t4_result_held", int'(result), 9);

    // T5: restart mid-image with a concurrent beat that must be dropped.
    start_pulse();
    for (int i = 0; i < 5; i++) send(20000 + i);
    chk("t5_busy_mid", int'(busy), 1);
    start = 1'b1; logit_valid_in = 1'b1; logit_data_in = 16'sd30000;
    @(posedge clock); #1;
    start = 1'b0; logit_valid_in = 1'b0;
    chk("t5_result_held", int'(result), 9);
    chk("t5_busy_restart", int'(busy), 1);
    img = '{10, -20, 30, 40, 500, 50, -60, 70, 80, 90};
    run_image(1'b0, 4, "t5");

    // T6: reset mid-image clears immediately; beats until next start ignored.
    start_pulse();
    for (int i = 0; i < 6; i++) send(1000 * (i + 1));
    reset = 1'b1;
    #1;
    chk("t6_result_rst", int'(result), 0);
    chk("t6_ready_rst", int'(logit_ready_out), 0);
    chk("t6_busy_rst", int'(busy), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) send(5000);
    chk("t6_ready_idle", int'(logit_ready_out), 0);
    start_pulse();
    img = '{-3, -2, -1, 4, 3, 2, 1, 0, 5, -9};
    run_image(1'b0, 8, "t6");

    // Every expected decision must have been observed.
    repeat (5) @(posedge clock);
    #1;
    chk("pending_expected", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
